// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the 5-stage teaching pipeline:
//                opcodes, instruction field positions, NOP encoding and the
//                ID/EX control bundle layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Instruction word width assumed by the decoder and field positions
    localparam int INSTR_BITS = 16;

    // Opcode encodings
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;

    // Field bit positions: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] imm
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 2;
    localparam int IMM_LO = 0;

    // Bubble / no-operation instruction word
    localparam logic [INSTR_BITS-1:0] NOP_INSTR = 16'h0000;

    // ID/EX control bundle; an all-zero value is a bubble
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] imm;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_decode.sv
`default_nettype none
// ============================================================================
//  Module      : id_decode
//  Description : Combinational instruction decoder. Maps an instruction word
//                to the ID/EX control bundle, suppressing reg_write for rd=0
//                and mapping unused opcodes (9-15) to NOP control.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_decode
    import pipe_pkg::*;
(
    input  logic [INSTR_BITS-1:0] instr,
    output ctrl_t                 ctrl
);

    logic [3:0] w_opcode;
    logic [2:0] w_rd;

    assign w_opcode = instr[OPC_HI:OPC_LO];
    assign w_rd     = instr[RD_HI:RD_LO];

    // Field extraction plus opcode-driven control; unknown opcodes keep control at 0
    always_comb begin
        ctrl           = '0;
        ctrl.valid     = 1'b1;
        ctrl.opcode    = w_opcode;
        ctrl.rd        = w_rd;
        ctrl.rs1       = instr[RS1_HI:RS1_LO];
        ctrl.rs2       = instr[RS2_HI:RS2_LO];
        ctrl.imm       = instr[IMM_HI:IMM_LO];
        case (w_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: ctrl.reg_write = 1'b1;
            OP_LD: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_ST:   ctrl.mem_write = 1'b1;
            OP_BEQ:  ctrl.branch    = 1'b1;
            default: ;
        endcase
        // r0 is hard-wired, so writes to it are dropped here
        if (w_rd == 3'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_front_end.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_front_end
//  Description : Fetch/decode front end. Holds the PC, IF/ID and ID/EX
//                registers, applies hazard-unit stalls/flushes and EX-stage
//                branch redirects, and keeps saturating stall/bubble counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_front_end
    import pipe_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pc_write,
    input  logic               if_id_write,
    input  logic               id_ex_flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic [2:0]         id_rs1,
    output logic [2:0]         id_rs2,
    output logic               id_ex_valid,
    output logic               id_ex_reg_write,
    output logic               id_ex_mem_read,
    output logic               id_ex_mem_write,
    output logic               id_ex_branch,
    output logic [3:0]         id_ex_opcode,
    output logic [2:0]         id_ex_rd,
    output logic [2:0]         id_ex_rs1,
    output logic [2:0]         id_ex_rs2,
    output logic [2:0]         id_ex_imm,
    output logic [PC_W-1:0]    id_ex_pc,
    output logic [7:0]         stall_cnt,
    output logic [7:0]         bubble_cnt
);

    localparam logic [PC_W-1:0] c_pc_one  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]      c_cnt_max = 8'hFF;

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_if_instr;
    logic [PC_W-1:0]    r_if_pc;
    logic               r_if_valid;
    ctrl_t              r_id_ex;
    logic [PC_W-1:0]    r_id_ex_pc;
    logic [7:0]         r_stall_cnt;
    logic [7:0]         r_bubble_cnt;

    ctrl_t              w_dec;
    logic               w_bubble;
    logic               w_stall_evt;
    logic               w_bubble_evt;

    id_decode u_id_decode (
        .instr (r_if_instr),
        .ctrl  (w_dec)
    );

    // A redirect kills the IF/ID occupant too, so it always yields a bubble
    assign w_bubble     = branch_taken | id_ex_flush | ~r_if_valid;
    assign w_stall_evt  = ~pc_write & ~branch_taken;
    assign w_bubble_evt = id_ex_flush | branch_taken;

    // PC: redirect beats stall, otherwise sequential (wraps naturally)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_pc <= branch_target;
        end else if (pc_write) begin
            r_pc <= r_pc + c_pc_one;
        end
    end

    // IF/ID: squash on redirect, hold on stall, else capture the fetch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
        end else if (branch_taken) begin
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else if (if_id_write) begin
            r_if_instr <= imem_rdata;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
        end
    end

    // ID/EX: never held; either a zeroed bubble or the decode of IF/ID
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_id_ex    <= '0;
            r_id_ex_pc <= '0;
        end else if (w_bubble) begin
            r_id_ex    <= '0;
            r_id_ex_pc <= '0;
        end else begin
            r_id_ex    <= w_dec;
            r_id_ex_pc <= r_if_pc;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_bubble_evt && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + 8'd1;
            end
        end
    end

    assign imem_addr       = r_pc;
    assign pc              = r_pc;
    assign if_id_instr     = r_if_instr;
    assign if_id_pc        = r_if_pc;
    assign if_id_valid     = r_if_valid;
    assign id_rs1          = r_if_instr[RS1_HI:RS1_LO];
    assign id_rs2          = r_if_instr[RS2_HI:RS2_LO];
    assign id_ex_valid     = r_id_ex.valid;
    assign id_ex_reg_write = r_id_ex.reg_write;
    assign id_ex_mem_read  = r_id_ex.mem_read;
    assign id_ex_mem_write = r_id_ex.mem_write;
    assign id_ex_branch    = r_id_ex.branch;
    assign id_ex_opcode    = r_id_ex.opcode;
    assign id_ex_rd        = r_id_ex.rd;
    assign id_ex_rs1       = r_id_ex.rs1;
    assign id_ex_rs2       = r_id_ex.rs2;
    assign id_ex_imm       = r_id_ex.imm;
    assign id_ex_pc        = r_id_ex_pc;
    assign stall_cnt       = r_stall_cnt;
    assign bubble_cnt      = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_front_end.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_front_end
//  Description : Scoreboard bench for pipe_front_end with a behavioural
//                reference of the fetch/decode pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_front_end;

    logic        clk;
    logic        rstn;
    logic        pc_write, if_id_write, id_ex_flush, branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  pc;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic [2:0]  id_rs1, id_rs2;
    logic        id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch;
    logic [3:0]  id_ex_opcode;
    logic [2:0]  id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_imm;
    logic [7:0]  id_ex_pc;
    logic [7:0]  stall_cnt, bubble_cnt;

    logic [15:0] rom [0:255];
    assign imem_rdata = rom[imem_addr];

    pipe_front_end #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rstn(rstn),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_ex_valid(id_ex_valid), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_branch(id_ex_branch), .id_ex_opcode(id_ex_opcode),
        .id_ex_rd(id_ex_rd), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected architectural snapshot after one clock edge
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] if_instr;
        logic [7:0]  if_pc;
        logic        if_valid;
        logic        v, rw, mr, mw, br;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2, imm;
        logic [7:0]  ex_pc;
        logic [7:0]  stall, bubble;
    } exp_t;

    exp_t sb[$];
    exp_t m;        // reference state
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_reset();
        exp_t r;
        r = '0;
        r.pc = 8'h00;
        return r;
    endfunction

    // One clock edge of the front end expressed from the pipeline rules
    function automatic exp_t ref_next(input exp_t s, input logic pw, input logic iw,
                                      input logic fl, input logic bt, input logic [7:0] tgt);
        exp_t n;
        logic [3:0] op;
        logic [2:0] rd;
        n  = s;
        op = s.if_instr[15:12];
        rd = s.if_instr[11:9];
        if (bt || fl || !s.if_valid) begin
            {n.v, n.rw, n.mr, n.mw, n.br, n.op, n.rd, n.rs1, n.rs2, n.imm, n.ex_pc} = '0;
        end else begin
            n.v     = 1'b1;
            n.rw    = (op >= 4'd1 && op <= 4'd6) && (rd != 3'd0);
            n.mr    = (op == 4'd6);
            n.mw    = (op == 4'd7);
            n.br    = (op == 4'd8);
            n.op    = op;
            n.rd    = rd;
            n.rs1   = s.if_instr[8:6];
            n.rs2   = s.if_instr[5:3];
            n.imm   = s.if_instr[2:0];
            n.ex_pc = s.if_pc;
        end
        if (bt) begin
            n.if_instr = 16'h0000;
            n.if_valid = 1'b0;
        end else if (iw) begin
            n.if_instr = rom[s.pc];
            n.if_pc    = s.pc;
            n.if_valid = 1'b1;
        end
        if (bt)      n.pc = tgt;
        else if (pw) n.pc = 8'((int'(s.pc) + 1) % 256);
        if (!pw && !bt && s.stall < 8'd255)  n.stall  = s.stall + 8'd1;
        if ((fl || bt) && s.bubble < 8'd255) n.bubble = s.bubble + 8'd1;
        return n;
    endfunction

    // Monitor: compare every edge for which stimulus queued an expectation
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("pc",          pc,          mon_e.pc);
            chk("if_id_instr", if_id_instr, mon_e.if_instr);
            chk("if_id_pc",    if_id_pc,    mon_e.if_pc);
            chk("if_id_valid", if_id_valid, mon_e.if_valid);
            chk("id_rs1_rs2",  {id_rs1, id_rs2}, {mon_e.if_instr[8:6], mon_e.if_instr[5:3]});
            chk("id_ex_ctrl",  {id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch},
                               {mon_e.v, mon_e.rw, mon_e.mr, mon_e.mw, mon_e.br});
            chk("id_ex_fields", {id_ex_opcode, id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_imm},
                                {mon_e.op, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.imm});
            chk("id_ex_pc",    id_ex_pc,    mon_e.ex_pc);
            chk("counters",    {stall_cnt, bubble_cnt}, {mon_e.stall, mon_e.bubble});
        end
    end

    // Called at a falling edge: drive, predict, wait one full cycle
    task automatic step(input logic pw, input logic iw, input logic fl,
                        input logic bt, input logic [7:0] tgt);
        pc_write      = pw;
        if_id_write   = iw;
        id_ex_flush   = fl;
        branch_taken  = bt;
        branch_target = tgt;
        m = ref_next(m, pw, iw, fl, bt, tgt);
        sb.push_back(m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // Drop reset mid-cycle, confirm immediate reset values, release next falling edge
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_pc",       pc,          8'h00);
        chk("rst_if_id",    {if_id_valid, if_id_instr, if_id_pc}, 25'h0);
        chk("rst_id_ex",    {id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                             id_ex_branch, id_ex_opcode, id_ex_rd, id_ex_pc}, 20'h0);
        chk("rst_counters", {stall_cnt, bubble_cnt}, 16'h0);
        m = ref_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1;
        pc_write = 1'b1; if_id_write = 1'b1; id_ex_flush = 1'b0;
        branch_taken = 1'b0; branch_target = 8'h00;
        for (int i = 0; i < 256; i++) begin
            rom[i] = {4'h1, 3'((i % 7) + 1), 3'(i % 8), 3'((i + 3) % 8), 3'(i % 8)};
        end
        rom[8'h10] = {4'h1, 3'd0, 3'd2, 3'd3, 3'd0};   // ADD with rd = 0
        rom[8'h11] = 16'hF123;                        // unused opcode
        m = ref_reset();

        // Reset and free run of ADDs
        @(negedge clk);
        do_reset();
        run(6);
        chk("free_pc",       pc, 8'h06);
        chk("free_ex_pc",    id_ex_pc, 8'h04);
        chk("free_counters", {stall_cnt, bubble_cnt}, 16'h0);

        // Load-use stall: LD r1 at 0, ADD r2,r1,r3 at 1
        rom[0] = {4'h6, 3'd1, 3'd0, 3'd0, 3'd2};
        rom[1] = {4'h1, 3'd2, 3'd1, 3'd3, 3'd0};
        do_reset();
        run(2);
        chk("lu_ld_in_ex", {id_ex_valid, id_ex_mem_read, id_ex_rd}, {1'b1, 1'b1, 3'd1});
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("lu_pc_hold",  pc, 8'h02);
        chk("lu_bubble",   id_ex_valid, 1'b0);
        run(1);
        chk("lu_add_in_ex", {id_ex_valid, id_ex_opcode, id_ex_rs1, id_ex_pc}, {1'b1, 4'h1, 3'd1, 8'h01});
        chk("lu_counters", {stall_cnt, bubble_cnt}, {8'd1, 8'd1});

        // Branch redirect at pc = 0x05
        do_reset();
        run(5);
        chk("br_pc_pre", pc, 8'h05);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h40);
        chk("br_redirect", {pc, if_id_valid, id_ex_valid}, {8'h40, 1'b0, 1'b0});
        run(2);
        chk("br_target_in_ex", {id_ex_valid, id_ex_pc}, {1'b1, 8'h40});

        // Branch during stall
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
        chk("br_stall_pc",  pc, 8'h80);
        chk("br_stall_cnt", stall_cnt, 8'd1);

        // PC wrap
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
        run(1);
        chk("wrap_ff", pc, 8'hFF);
        run(1);
        chk("wrap_00", pc, 8'h00);

        // Decode edge cases
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
        run(2);
        chk("rd0_add", {id_ex_pc, id_ex_valid, id_ex_opcode, id_ex_reg_write}, {8'h10, 1'b1, 4'h1, 1'b0});
        run(1);
        chk("op_f", {id_ex_valid, id_ex_opcode, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch},
                    {1'b1, 4'hF, 4'b0000});

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 500; i++) begin
            int r;
            if (i == 250) do_reset();
            r = $urandom_range(0, 99);
            if (r < 8)       step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 8'($urandom));
            else if (r < 20) step(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom));
            else if (r < 28) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
            else             step(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        end

        // Saturation
        do_reset();
        repeat (300) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("stall_sat", stall_cnt, 8'hFF);
        repeat (300) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("bubble_sat", bubble_cnt, 8'hFF);

        #2;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_front_end.md
# pipe_front_end

Fetch/decode front end of the 5-stage teaching pipeline: holds the PC, the IF/ID register and the ID/EX register, and decodes instructions into ID/EX control. It is the consumer of the hazard unit's `pc_write` / `if_id_write` / `id_ex_flush` outputs and of the EX-stage branch redirect. It supplies the `rs1`/`rs2`/`rd`/`mem_read` fields the hazard and forwarding units inspect.

## Interface
- `PC_W`, 8, PC / instruction-address width
- `INSTR_W`, 16, instruction width
- `RESET_PC`, 8'h00, PC value after reset

- `clk`  in  1  rising-edge clock
- `rstn`  in  1  asynchronous, active-low reset
- `pc_write`  in  1  1 = PC may update; 0 = PC holds (stall)
- `if_id_write`  in  1  1 = IF/ID may load; 0 = IF/ID holds
- `id_ex_flush`  in  1  1 = load a bubble into ID/EX
- `branch_taken`  in  1  EX-stage redirect
- `branch_target`  in  PC_W  redirect address
- `imem_addr`  out  PC_W  instruction address, equals `pc`
- `imem_rdata`  in  INSTR_W  instruction, combinational read of `imem_addr`
- `pc`  out  PC_W  current PC
- `if_id_instr`  out  INSTR_W  / `if_id_pc` out PC_W / `if_id_valid` out 1  IF/ID contents
- `id_rs1`, `id_rs2`  out  3  source fields of `if_id_instr`, combinational, for the hazard unit
- `id_ex_valid`, `id_ex_reg_write`, `id_ex_mem_read`, `id_ex_mem_write`, `id_ex_branch`  out  1  ID/EX control
- `id_ex_opcode`  out  4 / `id_ex_rd`, `id_ex_rs1`, `id_ex_rs2`, `id_ex_imm`  out  3 / `id_ex_pc`  out  PC_W  ID/EX fields
- `stall_cnt`, `bubble_cnt`  out  8  saturating performance counters

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] imm. NOP = 16'h0000.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI: reg_write.
  - 6 LD: reg_write and mem_read.
  - 7 ST: mem_write.
  - 8 BEQ: branch.
  - 9–15: decode as NOP (all control 0), `id_ex_valid` still 1.
- `reg_write` is forced to 0 when rd = 0.
- PC update, in priority order:
  1. `branch_taken`: `pc` ← `branch_target`.
  2. `pc_write` = 0: hold.
  3. Otherwise `pc` ← `pc` + 1, modulo 2^PC_W (8'hFF → 8'h00).
- IF/ID update, in priority order:
  1. `branch_taken`: instr ← NOP, valid ← 0.
  2. `if_id_write` = 0: hold all fields.
  3. Otherwise instr ← `imem_rdata`, pc ← `pc`, valid ← 1.
- ID/EX update:
  - Bubble when `branch_taken`, `id_ex_flush`, or `if_id_valid` = 0. A bubble sets all control and valid to 0 and all fields to 0.
  - Otherwise ID/EX loads the decode of IF/ID.
  - ID/EX is never held; the hazard unit expresses stalls as a flush.
- `stall_cnt` increments on each cycle with `pc_write` = 0 and `branch_taken` = 0.
- `bubble_cnt` increments on each cycle in which ID/EX loads a bubble caused by `id_ex_flush` or `branch_taken`.
- Both counters saturate at 8'hFF.

## Timing
- Reset (async, immediate) values:
  - `pc` = RESET_PC.
  - IF/ID: instr = NOP, pc = 0, valid = 0.
  - ID/EX: all fields 0.
  - Both counters 0.
- Reset asserted mid-operation discards all in-flight state on that cycle.
- After `rstn` rises:
  - The first fetch (PC = RESET_PC) is in IF/ID after edge 1.
  - Its decode is in ID/EX after edge 2.
- Latency: one cycle per stage.
- `id_rs1` / `id_rs2` are combinational from the IF/ID register, with no added delay.
- Load-use stall (`pc_write` = 0, `if_id_write` = 0, `id_ex_flush` = 1 for one cycle) gives:
  - PC and IF/ID unchanged.
  - One bubble in ID/EX.
  - The dependent instruction enters ID/EX one cycle late.
- `branch_taken` has priority over every stall input in the same cycle. It kills both younger instructions (2-cycle penalty). `pc` = target on the next cycle.
- `imem_rdata` must be valid within the same cycle as `imem_addr`.

## Structure
- Shared package `pipe_pkg`:
  - opcode constants;
  - field bit positions;
  - `NOP_INSTR`;
  - ID/EX control-bundle layout.
- The same package is used by the hazard and forwarding units.
- One combinational sub-module `id_decode`: instruction → control bundle, including the rd = 0 suppression and illegal→NOP mapping.
- The PC, IF/ID, ID/EX and counters stay in `pipe_front_end`.

## Test plan
- **Reset, free run.** Reset, ROM of sequential ADDs, no stalls:
  - `pc` = 0,1,2,… every cycle.
  - `id_ex_pc` trails `pc` by 2.
  - Counters stay 0.
- **Load-use stall.** LD r1 at 0x00, ADD r2,r1,r3 at 0x01, one stall cycle applied on the matching cycle:
  - `pc` holds at 0x02 for one cycle.
  - ID/EX shows one bubble, then ADD.
  - `stall_cnt` = 1, `bubble_cnt` = 1.
- **Branch redirect.** `branch_taken` = 1, target 0x40, while `pc` = 0x05:
  - Next `pc` = 0x40.
  - `if_id_valid` = 0.
  - ID/EX bubble.
  - Instruction at 0x40 reaches ID/EX two edges later.
- **Branch during stall.** `branch_taken` = 1 with `pc_write` = 0 in the same cycle:
  - `pc` = target.
  - `stall_cnt` unchanged.
- **Wrap and decode edge cases.**
  - PC 0xFF increments to 0x00.
  - ADD with rd = 0 gives `id_ex_reg_write` = 0.
  - Opcode 0xF gives all control 0, `id_ex_valid` = 1.
- **Async reset and saturation.**
  - `rstn` dropped mid-cycle: outputs reach reset values before the next edge.
  - 300 consecutive stall cycles: `stall_cnt` = 8'hFF.
